// File: rtl/mem_access_unit.sv
// Load/store unit: word-addressed data memory, sub-word stores as read-modify-write.
// Optional MISALIGN_CHECK_EN: reject misaligned or reserved-size requests with resp_error.
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic        req_err;
    logic [1:0]  req_size_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;
    logic [31:0] st_val;

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            SZ_RSVD: req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    // Reserved size behaves as a word access when it is not rejected.
    assign req_size_n = (req_size == SZ_RSVD) ? SZ_WORD : req_size;

    // Lane extraction and merge both work on the word currently presented by memory.
    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: ld_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ld_val = mem_rdata;
        endcase
        st_val = mem_rdata;
        case (size_q)
            SZ_BYTE: st_val[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            SZ_HALF: st_val[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            default: st_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size_n;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (req_write && req_size_n == SZ_WORD) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = READ;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            READ: begin
                if (wr_q) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = st_val;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_val;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
endmodule
